// File: rtl/axi_defs.sv
// Shared AXI3 encodings and the sequencer state type.
package axi_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R
  } state_e;

  // True when the burst's last word lies beyond the start word's 4KB page.
  function automatic logic crosses_4k(input logic [9:0] word_idx, input logic [3:0] len);
    return ({1'b0, word_idx} + {7'd0, len}) > 11'd1023;
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Burst beat counter shared by the write-data and read-data phases.
module axi_beat_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [3:0] len_i,
  output logic       last_o,
  output logic       over_o
);

  logic [4:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != 5'd31)) begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {1'b0, len_i});
  assign over_o = (cnt_q > {1'b0, len_i});

endmodule

// File: rtl/axi_master_sequencer.sv
// Turns one local read/write command into a single AXI3 burst, one command at a time.
module axi_master_sequencer
  import axi_defs::*;
#(
  parameter logic [3:0] AXI_ID   = 4'h0,
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  wstrb_in,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        rdata_last,
  output logic        done,
  output logic [1:0]  resp,
  output logic [3:0]  awid,
  output logic [31:0] awadr,
  output logic [3:0]  awlen,
  output logic        awvalid,
  input  logic        awready,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic [3:0]  wid,
  output logic [31:0] wrdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic        write_q, write_d;
  logic [1:0]  resp_q, resp_d;
  logic        done_q, done_d;
  logic        cnt_clr, cnt_inc, cnt_last, cnt_over;

  axi_beat_counter u_beat_cnt (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .len_i  (len_q),
    .last_o (cnt_last),
    .over_o (cnt_over)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    write_d = write_q;
    resp_d  = resp_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          write_d = cmd_write;
          resp_d  = RESP_OKAY;
          cnt_clr = 1'b1;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if ((addr_q[1:0] != 2'b00) || crosses_4k(addr_q[11:2], len_q)) begin
          resp_d  = RESP_SLVERR;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = write_q ? S_AW : S_AR;
        end
      end
      S_AW: if (awready) state_d = S_W;
      S_W: begin
        if (wdata_valid && wready) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = S_B;
        end
      end
      S_B: begin
        if (bvalid) begin
          resp_d  = (bid != AXI_ID) ? RESP_SLVERR : bresp;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_AR: if (arready) state_d = S_R;
      S_R: begin
        if (rvalid) begin
          cnt_inc = 1'b1;
          if ((resp_q == RESP_OKAY) && (rresp != RESP_OKAY)) resp_d = rresp;
          // Protocol violations override whatever the slave reported.
          if ((rid != AXI_ID) || (rlast && !cnt_last) || (!rlast && (cnt_last || cnt_over))) begin
            resp_d = RESP_SLVERR;
          end
          if (rlast) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      resp_q  <= RESP_OKAY;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      write_q <= write_d;
      resp_q  <= resp_d;
      done_q  <= done_d;
    end
  end

  // Held off for the done cycle so a new command is taken only after completion is seen.
  assign cmd_ready = aresetn && (state_q == S_IDLE) && !done_q;
  assign done      = done_q;
  assign resp      = resp_q;

  assign awid    = AXI_ID;
  assign awadr   = addr_q;
  assign awlen   = len_q;
  assign awvalid = (state_q == S_AW);
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = AXI_PROT;

  assign wid         = AXI_ID;
  assign wrdata      = wdata_in;
  assign wstrb       = wstrb_in;
  assign wvalid      = (state_q == S_W) && wdata_valid;
  assign wlast       = (state_q == S_W) && cnt_last;
  assign wdata_ready = (state_q == S_W) && wready;
  assign bready      = (state_q == S_B);

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arvalid = (state_q == S_AR);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = AXI_PROT;

  assign rready      = (state_q == S_R);
  assign rdata_out   = rdata;
  assign rdata_valid = (state_q == S_R) && rvalid;
  assign rdata_last  = (state_q == S_R) && rvalid && rlast;

endmodule

// File: tb/tb_axi_master_sequencer.sv
// Directed and randomized bench for axi_master_sequencer with a transaction-level reference model.
module tb_axi_master_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [31:0] wdata_in = '0;
  logic [3:0]  wstrb_in = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] rdata_out;
  logic        rdata_valid, rdata_last, done;
  logic [1:0]  resp;
  logic [3:0]  awid, awlen, wid, arid, arlen, awcache, arcache;
  logic [31:0] awadr, araddr, wrdata;
  logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, awlock, arburst, arlock;
  logic [3:0]  wstrb, bid = '0, rid = '0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, rready;

  always #5 aclk = ~aclk;

  axi_master_sequencer dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
    .done(done), .resp(resp),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Slave/source configuration for the next command.
  int          cfg_mode;   // 0 immediate, 1 random stalls, 2 wready toggling
  logic [3:0]  cfg_bid, cfg_rid;
  logic [1:0]  cfg_bresp;
  logic [31:0] wsrc_d[$];
  logic [3:0]  wsrc_s[$];
  logic [31:0] rb_data[$];
  logic [1:0]  rb_resp[$];
  bit          rb_last[$];

  // Observations of the last command.
  int          aw_hs, ar_hs, aw_seen, ar_seen, done_cnt, acc_cyc, done_cyc;
  logic [31:0] a_addr_o;
  logic [3:0]  a_len_o;
  logic [1:0]  done_resp;
  logic        rdy_after;
  logic [31:0] ow_d[$];
  logic [3:0]  ow_s[$];
  bit          ow_l[$];
  logic [31:0] or_d[$];
  bit          or_l[$];

  function automatic bit rdy();
    return (cfg_mode == 1) ? bit'($urandom % 2) : 1'b1;
  endfunction

  task automatic make_wr(input int n);
    wsrc_d = {};
    wsrc_s = {};
    for (int i = 0; i < n; i++) begin
      wsrc_d.push_back($urandom);
      wsrc_s.push_back(4'($urandom));
    end
  endtask

  task automatic make_rd(input int n, input int err_idx, input logic [1:0] err_resp);
    rb_data = {};
    rb_resp = {};
    rb_last = {};
    for (int i = 0; i < n; i++) begin
      rb_data.push_back($urandom);
      rb_resp.push_back((i == err_idx) ? err_resp : 2'b00);
      rb_last.push_back(i == n - 1);
    end
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len);
    int cyc = 0, wi = 0, ri = 0, post = 0;
    bit accepted = 0, b_pend = 0, r_act = 0, done_seen = 0;
    aw_hs = 0; ar_hs = 0; aw_seen = 0; ar_seen = 0; done_cnt = 0;
    acc_cyc = 0; done_cyc = 0; rdy_after = 1'b0; done_resp = 2'bxx;
    ow_d = {}; ow_s = {}; ow_l = {}; or_d = {}; or_l = {};
    while (post < 3 && cyc < 400) begin
      @(negedge aclk);
      cyc++;
      cmd_valid   = !accepted;
      cmd_write   = wr;
      cmd_addr    = addr;
      cmd_len     = len;
      awready     = rdy();
      arready     = rdy();
      wready      = (cfg_mode == 2) ? cyc[0] : rdy();
      wdata_valid = (wi < wsrc_d.size()) && ((cfg_mode != 1) || ($urandom % 4 != 0));
      wdata_in    = (wi < wsrc_d.size()) ? wsrc_d[wi] : 32'h0;
      wstrb_in    = (wi < wsrc_s.size()) ? wsrc_s[wi] : 4'h0;
      bvalid      = b_pend && ((cfg_mode != 1) || ($urandom % 2 == 0));
      bid         = cfg_bid;
      bresp       = cfg_bresp;
      rvalid      = r_act && (ri < rb_data.size()) && ((cfg_mode != 1) || ($urandom % 3 != 0));
      rdata       = (ri < rb_data.size()) ? rb_data[ri] : 32'h0;
      rresp       = (ri < rb_resp.size()) ? rb_resp[ri] : 2'b00;
      rlast       = (ri < rb_last.size()) ? rb_last[ri] : 1'b0;
      rid         = cfg_rid;
      #1;
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
      end
      if (awvalid) aw_seen++;
      if (arvalid) ar_seen++;
      if (awvalid && awready) begin
        aw_hs++;
        a_addr_o = awadr;
        a_len_o  = awlen;
      end
      if (arvalid && arready) begin
        ar_hs++;
        a_addr_o = araddr;
        a_len_o  = arlen;
        r_act    = 1;
      end
      if (wvalid && wready) begin
        ow_d.push_back(wrdata);
        ow_s.push_back(wstrb);
        ow_l.push_back(wlast);
        wi++;
        if (wlast) b_pend = 1;
      end
      if (bvalid && bready) b_pend = 0;
      if (rdata_valid) begin
        or_d.push_back(rdata_out);
        or_l.push_back(rdata_last);
      end
      if (rvalid && rready) ri++;
      if (done) begin
        done_cnt++;
        done_resp = resp;
        done_cyc  = cyc;
        done_seen = 1;
      end
      if (done_seen) post++;
      if (post == 2) rdy_after = cmd_ready;
    end
    @(negedge aclk);
    cmd_valid = 0; bvalid = 0; rvalid = 0; wdata_valid = 0;
  endtask

  // Reference: expected final response of a read from the beats the slave returned.
  function automatic logic [1:0] exp_read_resp(input logic [3:0] len);
    logic [1:0] r = 2'b00;
    bit bad = (cfg_rid != 4'h0) || (rb_data.size() != int'(len) + 1);
    foreach (rb_resp[i]) if (r == 2'b00 && rb_resp[i] != 2'b00) r = rb_resp[i];
    return bad ? 2'b10 : r;
  endfunction

  task automatic check_cmd(input string tag, input bit wr, input logic [31:0] addr, input logic [3:0] len);
    bit bad_cmd = (addr % 4) != 0 || (addr % 4096) + (int'(len) + 1) * 4 > 4096;
    logic [1:0] exp_r;
    if (bad_cmd) exp_r = 2'b10;
    else if (wr) exp_r = (cfg_bid != 4'h0) ? 2'b10 : cfg_bresp;
    else exp_r = exp_read_resp(len);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_resp"}, done_resp, exp_r);
    check({tag, "_ready_after"}, rdy_after, 1);
    if (bad_cmd) begin
      check({tag, "_no_axi"}, aw_seen + ar_seen, 0);
    end else if (wr) begin
      check({tag, "_aw_hs"}, aw_hs, 1);
      check({tag, "_ar_seen"}, ar_seen, 0);
      check({tag, "_awadr"}, a_addr_o, addr);
      check({tag, "_awlen"}, a_len_o, len);
      check({tag, "_wbeats"}, ow_d.size(), int'(len) + 1);
      foreach (ow_d[i]) begin
        if (i < wsrc_d.size()) begin
          check({tag, "_wdata"}, ow_d[i], wsrc_d[i]);
          check({tag, "_wstrb"}, ow_s[i], wsrc_s[i]);
        end
        check({tag, "_wlast"}, ow_l[i], (i == int'(len)));
      end
    end else begin
      check({tag, "_ar_hs"}, ar_hs, 1);
      check({tag, "_aw_seen"}, aw_seen, 0);
      check({tag, "_araddr"}, a_addr_o, addr);
      check({tag, "_arlen"}, a_len_o, len);
      check({tag, "_rbeats"}, or_d.size(), rb_data.size());
      foreach (or_d[i]) begin
        if (i < rb_data.size()) begin
          check({tag, "_rdata"}, or_d[i], rb_data[i]);
          check({tag, "_rlast"}, or_l[i], rb_last[i]);
        end
      end
    end
  endtask

  initial begin
    int beats, dones;
    bit hit, acc;
    cfg_mode = 0; cfg_bid = 4'h0; cfg_rid = 4'h0; cfg_bresp = 2'b00;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rready", rready, 0);
    check("rst_done", done, 0);
    check("rst_resp", resp, 0);
    check("rst_awadr", awadr, 0);
    check("rst_awlen", awlen, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check("idle_cmd_ready", cmd_ready, 1);
    check("awsize", awsize, 3'b010);
    check("awburst", awburst, 2'b01);
    check("arsize", arsize, 3'b010);
    check("arburst", arburst, 2'b01);
    check("awlock", {awlock, arlock, awcache, arcache}, 12'h000);
    check("prot_ids", {awprot, arprot, awid, wid, arid}, 18'h0);

    // Single-beat write with an always-ready slave
    make_wr(1);
    run_cmd(1'b1, 32'h1000, 4'd0);
    check_cmd("t1", 1'b1, 32'h1000, 4'd0);
    check("t1_latency", done_cyc - acc_cyc - 1, 4);

    // Four-beat write with wready toggling
    cfg_mode = 2;
    make_wr(4);
    run_cmd(1'b1, 32'h2040, 4'd3);
    check_cmd("t2", 1'b1, 32'h2040, 4'd3);

    // 16-beat read with SLVERR on beat 5
    cfg_mode = 0;
    wsrc_d = {}; wsrc_s = {};
    make_rd(16, 4, 2'b10);
    run_cmd(1'b0, 32'h3000, 4'd15);
    check_cmd("t3", 1'b0, 32'h3000, 4'd15);

    // 4KB crossing and misaligned commands
    run_cmd(1'b1, 32'h0FF8, 4'd3);
    check_cmd("t4_cross", 1'b1, 32'h0FF8, 4'd3);
    run_cmd(1'b0, 32'h0102, 4'd0);
    check_cmd("t4_align", 1'b0, 32'h0102, 4'd0);
    run_cmd(1'b0, 32'h0FFC, 4'd0);
    check_cmd("t4_edge", 1'b0, 32'h0FFC, 4'd0);

    // Early rlast, then a burst overrunning its length
    make_rd(2, -1, 2'b00);
    run_cmd(1'b0, 32'h4000, 4'd3);
    check_cmd("t5_short", 1'b0, 32'h4000, 4'd3);
    make_rd(4, -1, 2'b00);
    run_cmd(1'b0, 32'h4100, 4'd1);
    check_cmd("t5_long", 1'b0, 32'h4100, 4'd1);

    // Wrong IDs on B and R
    cfg_bid = 4'h5;
    make_wr(2);
    run_cmd(1'b1, 32'h5000, 4'd1);
    check_cmd("t5_bid", 1'b1, 32'h5000, 4'd1);
    cfg_bid = 4'h0;
    cfg_rid = 4'h7;
    make_rd(2, -1, 2'b00);
    run_cmd(1'b0, 32'h5100, 4'd1);
    check_cmd("t5_rid", 1'b0, 32'h5100, 4'd1);
    cfg_rid = 4'h0;

    // Reset while the second write beat is on the bus
    make_wr(4);
    beats = 0; hit = 0; acc = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge aclk);
      cmd_valid = !acc; cmd_write = 1'b1; cmd_addr = 32'h6000; cmd_len = 4'd3;
      awready = 1'b1; wready = 1'b1; wdata_valid = 1'b1;
      wdata_in = wsrc_d[beats]; wstrb_in = wsrc_s[beats];
      if (beats == 1) begin
        aresetn = 1'b0;
        hit = 1;
        #1;
      end else begin
        #1;
        if (cmd_valid && cmd_ready) acc = 1;
        if (wvalid && wready) beats++;
      end
    end
    check("mid_rst_reached", hit, 1);
    check("mid_rst_wvalid", wvalid, 0);
    check("mid_rst_wlast", wlast, 0);
    check("mid_rst_awvalid", awvalid, 0);
    check("mid_rst_wdata_ready", wdata_ready, 0);
    check("mid_rst_bready", bready, 0);
    check("mid_rst_done", done, 0);
    cmd_valid = 0; wdata_valid = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge aclk);
      #1;
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);
    make_wr(3);
    run_cmd(1'b1, 32'h6000, 4'd2);
    check_cmd("post_rst", 1'b1, 32'h6000, 4'd2);

    // Randomized commands with random stalls
    cfg_mode = 1;
    for (int k = 0; k < 12; k++) begin
      bit wr = bit'($urandom % 2);
      logic [3:0] len = 4'($urandom % 16);
      logic [31:0] addr = 32'h0001_0000 | ({20'h0, 10'($urandom), 2'b00});
      int n;
      if ($urandom % 8 == 0) addr[1:0] = 2'b01;
      cfg_bid   = ($urandom % 6 == 0) ? 4'h3 : 4'h0;
      cfg_rid   = ($urandom % 8 == 0) ? 4'h1 : 4'h0;
      cfg_bresp = 2'($urandom % 4);
      n = int'(len) + 1;
      if ($urandom % 6 == 0) n = n + 1;
      else if ($urandom % 6 == 0 && len > 0) n = n - 1;
      if (wr) begin
        make_wr(int'(len) + 1);
        rb_data = {}; rb_resp = {}; rb_last = {};
      end else begin
        wsrc_d = {}; wsrc_s = {};
        make_rd(n, int'($urandom % 20), 2'($urandom % 4));
      end
      run_cmd(wr, addr, len);
      check_cmd($sformatf("rnd%0d", k), wr, addr, len);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi_master_sequencer.md
Name:
axi_master_sequencer

Overview:
Converts one simple local command (read/write, address, beat count) into a complete AXI3 transaction on a single master port. It sequences the AW→W→B or AR→R channels and serves one command at a time. It sits between local engines and the fabric-facing AXI master port.

Parameters:
AXI_ID, 4'h0, constant driven on awid/wid/arid and expected on bid/rid
AXI_PROT, 3'b000, constant driven on awprot/arprot

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
cmd_valid/cmd_ready  input/output  1/1  command handshake
cmd_write  input  1  1=write, 0=read
cmd_addr  input  32  word-aligned start address
cmd_len  input  4  beats minus one (1..16 beats)
wdata_in/wstrb_in/wdata_valid  input  32/4/1  local write-data stream
wdata_ready  output  1  local write-data accept
rdata_out/rdata_valid/rdata_last  output  32/1/1  local read-data stream (no backpressure)
done/resp  output  1/2  one-cycle completion pulse, final response
awid,awadr,awlen,awvalid  output  4,32,4,1  write address; awready input 1
awsize,awburst,awlock,awcache,awprot  output  3,2,2,4,3  fixed 3'b010, 2'b01, 0, 0, AXI_PROT
wid,wrdata,wstrb,wlast,wvalid  output  4,32,4,1,1; wready input 1
bid,bresp,bvalid  input  4,2,1; bready output 1
arid,araddr,arlen,arvalid  output  4,32,4,1; arready input 1
arsize,arburst,arlock,arcache,arprot  output  fixed as AW equivalents
rid,rdata,rresp,rlast,rvalid  input  4,32,2,1,1; rready output 1

Behaviour:
- Async reset: state IDLE; every valid/ready/done/last output 0; resp 0; address/len/data registers 0. Reset mid-transaction abandons it immediately, with no completion.
- FSM states: IDLE, CHK, AW, W, B, AR, R. cmd_ready=1 only in IDLE.
- cmd_valid&cmd_ready latches addr/len/write → CHK.
- CHK (1 cycle): if addr[11:2]+len > 1023 (4KB crossing) or addr[1:0]≠0, pulse done with resp=2'b10 → IDLE, no AXI activity. Otherwise → AW (write) or AR (read).
- AW: awvalid=1 registered, awadr/awlen stable until awready. Handshake → W next cycle.
- W: wvalid=wdata_valid, wrdata=wdata_in, wstrb=wstrb_in (combinational pass-through); wdata_ready=wready.
  - Beat counter increments per wvalid&wready.
  - wlast=1 when count==len.
  - Last handshake → B.
- B: bready=1. On bvalid: resp=bresp, or 2'b10 if bid≠AXI_ID; done=1 next cycle → IDLE.
- AR: arvalid held until arready → R.
- R: rready=1. Each rvalid forwards rdata_out/rdata_valid/rdata_last the same cycle (combinational) and counts beats.
  - resp is sticky on the first non-OKAY rresp.
  - SLVERR is forced if rid≠AXI_ID, rlast arrives with count≠len, or count passes len without rlast.
  - rvalid&rlast → done next cycle → IDLE.
- Write and read never overlap. W is not started before the AW handshake, which is legal AXI.
- Counter width is 5 bits, with no wrap for len=15 (16 beats).
- done is exactly 1 cycle per accepted command. cmd_ready returns the cycle after done.

Decomposition:
- Shared package axi_defs: burst-type, response, and size constants (OKAY/EXOKAY/SLVERR/DECERR, INCR, SIZE_4B) and the FSM state encoding.
- Natural sub-module: axi_beat_counter (5-bit counter, clear/inc/last compare), instantiated once and shared by W and R.

Test Plan:
- Write, addr 0x1000, len 0, awready/wready/bvalid immediate, bresp OKAY → one AW, one W with wlast=1, done with resp=2'b00, 4 cycles from cmd accept to done.
- Write len 3 with wready toggling 1,0,1,0 → exactly 4 beats, wlast only on beat 4, data order preserved.
- Read len 15, rvalid continuous, rresp=2'b10 on beat 5 → 16 rdata_valid, rdata_last on beat 16, resp=2'b10.
- Command addr 0x0FF8, len 3 → done with resp=2'b10, awvalid/arvalid never asserted.
- Read len 3 with rlast on beat 2 → resp=2'b10, done after beat 2, FSM back to IDLE.
- aresetn low during W beat 2 → all valid outputs 0 same cycle, no done; a subsequent command completes normally.
